// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, MEM-stage state enum and MEM/WB bundle
package pipeline_pkg;
   localparam int PIPE_WORD_W = 32;
   localparam int DST_W       = 4;
   localparam int CNT_W       = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic                   WB_en;
      logic                   mem_read;
      logic [DST_W-1:0]       dst;
      logic [PIPE_WORD_W-1:0] ALU_res;
      logic [PIPE_WORD_W-1:0] mem_data;
   } memwb_t;
endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word array with synchronous write and combinational read (not reset)
module data_memory #(
   parameter int WORD_WIDTH  = 32,
   parameter int DEPTH_WORDS = 64
) (
   input  logic                           clk,
   input  logic                           i_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
   input  logic [WORD_WIDTH-1:0]          i_wdata,
   output logic [WORD_WIDTH-1:0]          o_rdata
);
   logic [WORD_WIDTH-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: wait-state FSM, address translation, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN adds misalignment/range faulting with a sticky fault flag.
module mem_stage
   import pipeline_pkg::*;
#(
   parameter int WORD_WIDTH  = PIPE_WORD_W,
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 4,
   parameter int ADDR_BASE   = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  WB_en_in,
   input  logic [DST_W-1:0]      dst_in,
   input  logic [WORD_WIDTH-1:0] ALU_res_in,
   input  logic [WORD_WIDTH-1:0] val_Rm_in,
   output logic                  ready,
   output logic                  WB_en_out,
   output logic                  mem_read_out,
   output logic [DST_W-1:0]      dst_out,
   output logic [WORD_WIDTH-1:0] ALU_res_out,
   output logic [WORD_WIDTH-1:0] mem_data_out,
   output logic                  fault
);
   localparam int                    IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0]      WAIT_L = CNT_W'(WAIT_CYCLES);
   localparam logic [WORD_WIDTH-1:0] BASE_L = WORD_WIDTH'(ADDR_BASE);

   state_t                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   memwb_t                r_pipe, w_pipe_nxt;
   logic                  r_fault;
   logic                  w_ready, w_req, w_commit, w_fault, w_bad, w_we;
   logic                  w_misalign, w_range;
   logic [WORD_WIDTH-1:0] w_offset, w_rdata;
   logic [IDX_W-1:0]      w_index;

   assign w_req      = mem_read_in | mem_write_in;
   assign w_offset   = ALU_res_in - BASE_L;
   assign w_index    = w_offset[IDX_W+1:2];
   assign w_misalign = |w_offset[1:0];
   assign w_range    = |(w_offset >> (IDX_W + 2));

`ifdef MEM_ALIGN_CHECK_EN
   assign w_fault = w_misalign | w_range;
`else
   logic w_unused_chk;
   assign w_unused_chk = w_misalign | w_range;
   assign w_fault      = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready     = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_req && (WAIT_L != '0)) begin
               w_ready     = 1'b0;
               w_state_nxt = BUSY;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         BUSY: begin
            if (r_cnt < WAIT_L) begin
               w_ready   = 1'b0;
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Commit happens on the single edge where ready is high with a request present.
   assign w_commit = w_ready & w_req;
   assign w_bad    = w_commit & w_fault;
   assign w_we     = w_commit & mem_write_in & ~w_fault & ~rst;

   data_memory #(
      .WORD_WIDTH  (WORD_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_dmem (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_index),
      .i_wdata (val_Rm_in),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_pipe_nxt          = '0;
      w_pipe_nxt.WB_en    = WB_en_in & ~(w_fault & mem_read_in);
      w_pipe_nxt.mem_read = mem_read_in;
      w_pipe_nxt.dst      = dst_in;
      w_pipe_nxt.ALU_res  = ALU_res_in;
      w_pipe_nxt.mem_data = (w_fault & w_req) ? '0 : w_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pipe  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_ready) begin
            r_pipe <= w_pipe_nxt;
         end
         if (w_bad) begin
            r_fault <= 1'b1;
         end
      end
   end

   assign ready        = w_ready;
   assign WB_en_out    = r_pipe.WB_en;
   assign mem_read_out = r_pipe.mem_read;
   assign dst_out      = r_pipe.dst;
   assign ALU_res_out  = r_pipe.ALU_res;
   assign mem_data_out = r_pipe.mem_data;
   assign fault        = r_fault;
endmodule
